uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, number of receive FIFO entries (power of 2, >=2).
REQ-003 The block SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-006 The block SHALL have port clks_per_bit_i  input  16  clocks per bit period (legal 4..65535).
REQ-007 The block SHALL have port parity_en_i  input  1  parity bit present after the data bits.
REQ-008 The block SHALL have port parity_odd_i  input  1  1 = odd parity, 0 = even parity.
REQ-009 The block SHALL have port stop2_i  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 The block SHALL have port rx_ready_i  input  1  consumer accepts the head FIFO entry.
REQ-011 The block SHALL have port rx_valid_o  output  1  FIFO not empty.
REQ-012 The block SHALL have port rx_data_o  output  DATA_WIDTH  head-entry data, LSB = first received bit.
REQ-013 The block SHALL have port frame_err_o  output  1  head entry had a stop bit sampled 0.
REQ-014 The block SHALL have port parity_err_o  output  1  head entry failed the parity check.
REQ-015 The block SHALL have port overflow_o  output  1  one-cycle pulse, completed frame dropped.
REQ-016 The block SHALL have port fifo_level_o  output  $clog2(FIFO_DEPTH+1)  current entry count.
REQ-017 The block SHALL have port busy_o  output  1  receiver FSM not in IDLE.

Function
REQ-018 rx_i SHALL pass through a two-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with busy_o = (state != IDLE).
REQ-020 IDLE SHALL go to START only on a synchronized falling edge (previous 1, current 0), so a held-low line (break) never retriggers.
REQ-021 On leaving IDLE, clks_per_bit_i, parity_en_i, parity_odd_i and stop2_i SHALL be latched; changes mid-frame SHALL have no effect.
REQ-022 START SHALL sample at count == (cpb-1)>>1; on 0 it SHALL clear the counter and go to DATA; on 1 it SHALL return to IDLE with no push and no error.
REQ-023 DATA, PARITY and STOP SHALL each sample when the 16-bit counter reaches cpb-1, then clear the counter.
REQ-024 DATA bits SHALL be stored LSB-first; after DATA_WIDTH bits the FSM SHALL go to PARITY if parity is latched enabled, else to STOP.
REQ-025 The parity error SHALL be set when (XOR of the data bits XOR the parity bit) != latched parity_odd.
REQ-026 STOP SHALL set the frame error if any stop sample is 0; with stop2 latched, STOP SHALL repeat once.
REQ-027 On the edge of the final stop sample, {frame_err, parity_err, data} SHALL be pushed and the FSM SHALL return to IDLE.
REQ-028 rx_valid_o SHALL rise the cycle after a push into an empty FIFO (one-cycle latency).
REQ-029 A pop SHALL occur when rx_valid_o && rx_ready_i; rx_data_o, frame_err_o and parity_err_o SHALL be 0 when the FIFO is empty.
REQ-030 A push while full SHALL be accepted if a pop occurs in the same cycle; otherwise the frame SHALL be dropped, the FIFO left unchanged, and overflow_o pulsed for 1 cycle.
REQ-031 A simultaneous push and pop SHALL leave fifo_level_o unchanged; the read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-032 With rst_ni low at a clock edge, the block SHALL go to IDLE, reset the synchronizer flops to 1, and clear the counter, bit index and FIFO pointers.
REQ-033 Under reset, outputs SHALL be rx_valid_o=0, rx_data_o=0, frame_err_o=0, parity_err_o=0, overflow_o=0, fifo_level_o=0 and busy_o=0.
REQ-034 Reset mid-frame SHALL discard the partial frame and all FIFO contents.

Configuration
REQ-035 With macro UART_RX_MAJORITY_EN defined, each sample SHALL be the 2-of-3 majority of the synchronized values at counts target-2, target-1 and target.
REQ-036 With UART_RX_MAJORITY_EN undefined, each sample SHALL be the single synchronized value at the target count; all other behaviour SHALL be identical.

Verification
REQ-037 cpb=16, 8N1, byte 0xA5, ready=1 -> exactly one entry 0xA5, with frame_err_o=0 and parity_err_o=0, and rx_valid_o high for 1 cycle.
REQ-038 cpb=16, even parity, data 0x03 with parity bit 1 -> entry 0x03 with parity_err_o=1; the same frame with parity bit 0 -> parity_err_o=0.
REQ-039 Frame 0x55 with stop bit 0, then the line held low for 3 bit times -> one entry 0x55 with frame_err_o=1 and no further entries until the line goes high and falls again.
REQ-040 ready=0, 5 frames 0x01..0x05 -> fifo_level_o=4 and one overflow_o pulse; popping yields 0x01..0x04 in order.
REQ-041 Low glitch of 3 cycles at cpb=16 -> busy_o pulses, no entry and no error; then a valid 0x3C is received correctly.
REQ-042 Reset mid-DATA with 2 entries queued -> fifo_level_o=0 and rx_valid_o=0; the next frame 0xC3 is received; with the macro, a 1-cycle inversion at a sample point still yields the correct byte.

Source files
------------

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: UART receiver with configurable framing and a small receive FIFO.
// The serial line is synchronised, framed by an IDLE/START/DATA/PARITY/STOP FSM,
// and completed frames are queued as {frame_err, parity_err, data}.
// Optional build macro: UART_RX_MAJORITY_EN. When defined, each bit sample is the
// 2-of-3 majority of the synchronised line at counts target-2, target-1 and target.
// When undefined, the single synchronised value at the target count is used.
module uart_rx_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             rx_i,
  input  logic [15:0]                      clks_per_bit_i,
  input  logic                             parity_en_i,
  input  logic                             parity_odd_i,
  input  logic                             stop2_i,
  input  logic                             rx_ready_i,
  output logic                             rx_valid_o,
  output logic [DATA_WIDTH-1:0]            rx_data_o,
  output logic                             frame_err_o,
  output logic                             parity_err_o,
  output logic                             overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Line synchroniser and one-cycle history (history also feeds edge detect)
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  logic w_sample, w_fall;

  // Receiver state
  state_t                r_state;
  logic [15:0]           r_cnt, r_cpb;
  logic                  r_par_en, r_par_odd, r_stop2;
  logic [BW-1:0]         r_bit_idx;
  logic                  r_stop_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_acc, r_par_err, r_frame_err;
  logic                  w_start_hit, w_bit_hit;

  // FIFO
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic          w_push, w_pop, w_full, w_wr;
  logic [EW-1:0] w_push_word, w_head;

  // Two-flop synchroniser; idle-high reset values avoid a false start after reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_rx_prev2;

  // Second history tap so the vote can see target-2, target-1 and target
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_prev2 <= 1'b1;
    end else begin
      r_rx_prev2 <= r_rx_prev;
    end
  end

  assign w_sample = (r_rx_prev2 & r_rx_prev) | (r_rx_prev2 & r_rx_sync) | (r_rx_prev & r_rx_sync);
`else
  assign w_sample = r_rx_sync;
`endif

  // A start needs a real 1->0 transition, so a held-low break cannot retrigger
  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_start_hit = (r_cnt == ((r_cpb - 16'd1) >> 1));
  assign w_bit_hit   = (r_cnt == (r_cpb - 16'd1));

  assign w_push      = (r_state == S_STOP) && w_bit_hit && (!r_stop2 || r_stop_idx);
  assign w_push_word = {r_frame_err | ~w_sample, r_par_err, r_shift};

  // Frame FSM: configuration is latched at the start edge and held for the frame
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cpb       <= '0;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_stop2     <= 1'b0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_par_acc   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_cpb       <= clks_per_bit_i;
            r_par_en    <= parity_en_i;
            r_par_odd   <= parity_odd_i;
            r_stop2     <= stop2_i;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (w_start_hit) begin
            r_cnt   <= '0;
            r_state <= w_sample ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_hit) begin
            r_cnt     <= '0;
            r_shift   <= {w_sample, r_shift[DATA_WIDTH-1:1]};
            r_par_acc <= r_par_acc ^ w_sample;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BW'(1);
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_hit) begin
            r_cnt     <= '0;
            r_par_err <= ((r_par_acc ^ w_sample) != r_par_odd);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_hit) begin
            r_cnt <= '0;
            if (!w_sample) r_frame_err <= 1'b1;
            if (r_stop2 && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_full = (r_level == FULL_LEVEL);
  assign w_pop  = (r_level != '0) && rx_ready_i;
  assign w_wr   = w_push && (!w_full || w_pop);

  // FIFO storage write port; contents are qualified by the level, so no reset
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= w_push_word;
  end

  // FIFO pointers, level and overflow pulse; pointers wrap by natural overflow
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_wr)  r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign rx_valid_o   = (r_level != '0);
  assign rx_data_o    = rx_valid_o ? w_head[DATA_WIDTH-1:0] : '0;
  assign parity_err_o = rx_valid_o & w_head[DATA_WIDTH];
  assign frame_err_o  = rx_valid_o & w_head[DATA_WIDTH+1];
  assign overflow_o   = r_overflow;
  assign fifo_level_o = r_level;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed frames against a queue model of the expected FIFO contents.
// Build with UART_RX_MAJORITY_EN defined to also exercise the sample-voting case.
module tb_uart_rx_ext;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_i = 1'b1;
  logic [15:0] clks_per_bit_i = 16'd16;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        stop2_i = 1'b0;
  logic        rx_ready_i = 1'b1;
  logic        rx_valid_o;
  logic [7:0]  rx_data_o;
  logic        frame_err_o;
  logic        parity_err_o;
  logic        overflow_o;
  logic [2:0]  fifo_level_o;
  logic        busy_o;

  uart_rx_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .clks_per_bit_i(clks_per_bit_i),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop2_i(stop2_i),
    .rx_ready_i(rx_ready_i), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o), .overflow_o(overflow_o),
    .fifo_level_o(fifo_level_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];          // expected {frame_err, parity_err, data} in order
  int exp_ovf = 0;
  int ovf_seen = 0;
  int pops = 0;
  int valid_cycles = 0;
  bit busy_seen = 1'b0;
  logic [9:0] last_pop = '0;

  // Compare process: every out-of-reset cycle the head must match the model queue
  always @(negedge clk_i) begin
    if (rst_ni) begin
      checks++;
      if ((fifo_level_o != 3'd0) !== rx_valid_o) begin
        errors++;
        $display("FAIL valid_vs_level: valid=%0b level=%0d", rx_valid_o, fifo_level_o);
      end
      if (rx_valid_o) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_entry: got %h, expected no entry", {frame_err_o, parity_err_o, rx_data_o});
        end else if ({frame_err_o, parity_err_o, rx_data_o} !== exp_q[0]) begin
          errors++;
          $display("FAIL head_entry: got %h, expected %h", {frame_err_o, parity_err_o, rx_data_o}, exp_q[0]);
        end
        if (rx_ready_i) begin
          last_pop = {frame_err_o, parity_err_o, rx_data_o};
          pops++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end else if ({frame_err_o, parity_err_o, rx_data_o} !== 10'h000) begin
        errors++;
        $display("FAIL empty_outputs: got %h, expected 000", {frame_err_o, parity_err_o, rx_data_o});
      end
      if (overflow_o) ovf_seen++;
      if (busy_o) busy_seen = 1'b1;
    end
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("check %s: %0h ok", name, act);
    end
  endtask

  // Model of one completed frame: enqueue, or count a drop when full and not draining
  task automatic expect_word(input logic [9:0] w);
    if (!rx_ready_i && exp_q.size() >= DEPTH) exp_ovf++;
    else exp_q.push_back(w);
  endtask

  // Drive one frame cycle-by-cycle; glitch inverts the line on that single cycle,
  // flip perturbs every frame-setting input once the frame is under way
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s0,
                            input logic s1, input int glitch, input bit flip, input bit end_low);
    int cp;
    int nb;
    logic [11:0] bits;
    logic pen, st2, podd;
    logic [9:0] w;
    cp   = int'(clks_per_bit_i);
    pen  = parity_en_i;
    st2  = stop2_i;
    podd = parity_odd_i;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (pen) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = s0;
    nb++;
    if (st2) begin
      bits[nb] = s1;
      nb++;
    end
    w = {(!s0 || (st2 && !s1)), (pen && ((^d ^ pbit) != podd)), d};
    expect_word(w);
    $display("frame data=%h par_en=%0b stop2=%0b expect=%h", d, pen, st2, w);
    for (int c = 0; c < nb * cp; c++) begin
      rx_i = bits[c / cp] ^ (c == glitch);
      if (flip && c == cp) begin
        parity_en_i    = !pen;
        stop2_i        = !st2;
        parity_odd_i   = !podd;
        clks_per_bit_i = 16'(cp * 2);
      end
      hold(1);
    end
    if (flip) begin
      parity_en_i    = pen;
      stop2_i        = st2;
      parity_odd_i   = podd;
      clks_per_bit_i = 16'(cp);
    end
    if (!end_low) begin
      rx_i = 1'b1;
      hold(2 * cp);
    end
  endtask

  int p0;
  int o0;

  initial begin
    // Reset state
    hold(3);
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_data", rx_data_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_perr", parity_err_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    hold(20);

    // 8N1 0xA5, valid for exactly one cycle
    valid_cycles = 0;
    p0 = pops;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("a5_entry", last_pop, 10'h0A5);
    chk("a5_pops", pops - p0, 1);
    chk("a5_valid_cycles", valid_cycles, 1);

    // Even parity: wrong then right parity bit; then an odd-parity frame
    parity_en_i = 1'b1;
    parity_odd_i = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("par_bad", last_pop, 10'h103);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("par_good", last_pop, 10'h003);
    parity_odd_i = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("par_odd_good", last_pop, 10'h007);
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;

    // Stop bit 0 followed by a break: one errored entry, no retrigger
    p0 = pops;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1);
    rx_i = 1'b0;
    hold(3 * 16);
    rx_i = 1'b1;
    hold(2 * 16);
    chk("break_entry", last_pop, 10'h255);
    chk("break_pops", pops - p0, 1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("after_break", last_pop, 10'h05A);

    // Two stop bits with the second one low
    stop2_i = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    chk("stop2_ferr", last_pop, 10'h281);
    stop2_i = 1'b0;

    // Settings changed mid-frame must be ignored
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, -1, 1'b1, 1'b0);
    chk("cfg_latched", last_pop, 10'h096);

    // Minimum bit period
    clks_per_bit_i = 16'd4;
    send_frame(8'h69, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("cpb4_entry", last_pop, 10'h069);
    clks_per_bit_i = 16'd16;
    hold(8);

    // Overflow: five frames into a four-entry FIFO with no consumer
    rx_ready_i = 1'b0;
    o0 = ovf_seen;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("ovf_level", fifo_level_o, 4);
    chk("ovf_pulses", ovf_seen - o0, 1);
    p0 = pops;
    rx_ready_i = 1'b1;
    hold(10);
    chk("ovf_drain_pops", pops - p0, 4);
    chk("ovf_last", last_pop, 10'h004);
    chk("ovf_level_empty", fifo_level_o, 0);

    // Short low glitch: busy pulses, nothing is queued
    busy_seen = 1'b0;
    p0 = pops;
    rx_i = 1'b0;
    hold(3);
    rx_i = 1'b1;
    hold(3 * 16);
    chk("glitch_busy", busy_seen, 1);
    chk("glitch_pops", pops - p0, 0);
    chk("glitch_idle", busy_o, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("glitch_then_3c", last_pop, 10'h03C);

    // Reset in the middle of DATA with two entries queued
    rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("pre_rst_level", fifo_level_o, 2);
    rx_i = 1'b0;
    hold(16);
    rx_i = 1'b1;
    hold(32);
    chk("pre_rst_busy", busy_o, 1);
    rst_ni = 1'b0;
    exp_q.delete();
    hold(2);
    chk("midrst_level", fifo_level_o, 0);
    chk("midrst_valid", rx_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    rst_ni = 1'b1;
    rx_ready_i = 1'b1;
    hold(4);
`ifdef UART_RX_MAJORITY_EN
    // Inverted cycle lands exactly on the data-bit-0 sample point (cycle 8+16)
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 24, 1'b0, 1'b0);
`else
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
`endif
    chk("post_rst_c3", last_pop, 10'h0C3);

    // Model bookkeeping at the end
    chk("model_drained", exp_q.size(), 0);
    chk("ovf_total", ovf_seen, exp_ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
